// File: rtl/pagerank_pkg.sv
// rtl/pagerank_pkg.sv - shared types, constants and FSM encoding for the PageRank scatter stage
package pagerank_pkg;
  typedef logic [63:0] rank_t;
  typedef logic [31:0] node_id_t;
  typedef logic [32:0] inv_deg_t;

  localparam int FRAC_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    SCATTER,
    DRAIN,
    DONE
  } scatter_state_e;
endpackage

// File: rtl/pagerank_scatter_if.sv
// rtl/pagerank_scatter_if.sv - edge stream in, contribution stream out to the gather stage
interface pagerank_scatter_if;
  import pagerank_pkg::*;

  logic     edge_valid;
  node_id_t edge_src;
  node_id_t edge_dst;
  logic     edge_last;
  logic     edge_ready;
  rank_t    page_rank_scatter;
  node_id_t dest_id;
  logic     pagerank_ready;

  modport slave (
    input  edge_valid, edge_src, edge_dst, edge_last,
    output edge_ready, page_rank_scatter, dest_id, pagerank_ready
  );

  modport master (
    output edge_valid, edge_src, edge_dst, edge_last,
    input  edge_ready, page_rank_scatter, dest_id, pagerank_ready
  );
endinterface

// File: rtl/pagerank_fixmul.sv
// rtl/pagerank_fixmul.sv - Q32.32 x Q1.32 multiply renormalised to Q32.32
// PAGERANK_SCATTER_SATURATE_EN clamps results that overflow 64 bits instead of truncating.
module pagerank_fixmul
  import pagerank_pkg::*;
(
  input  rank_t    rank,
  input  inv_deg_t inv_deg,
  output rank_t    contrib
);
  logic [96:0] product;

  assign product = {33'd0, rank} * {64'd0, inv_deg};

`ifdef PAGERANK_SCATTER_SATURATE_EN
  logic [31:0] unused_frac;
  assign unused_frac = product[FRAC_BITS-1:0];
  assign contrib     = product[96] ? '1 : product[FRAC_BITS+63:FRAC_BITS];
`else
  logic [32:0] unused_bits;
  assign unused_bits = {product[96], product[FRAC_BITS-1:0]};
  assign contrib     = product[FRAC_BITS+63:FRAC_BITS];
`endif
endmodule

// File: rtl/pagerank_scatter.sv
// rtl/pagerank_scatter.sv - two-stage scatter pipeline: edge register, then rank x inv-degree to outputs
// Saturation of overflowing contributions is enabled by PAGERANK_SCATTER_SATURATE_EN (see pagerank_fixmul).
module pagerank_scatter
  import pagerank_pkg::*;
#(
  parameter int NODES_IN_GRAPH = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  rank_t             pagerank_in    [NODES_IN_GRAPH],
  input  inv_deg_t          inv_out_degree [NODES_IN_GRAPH],
  pagerank_scatter_if.slave bus,
  output logic              scatter_operation_complete,
  output logic [15:0]       dropped_edges
);
  localparam int IDX_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

  scatter_state_e   state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_inr_q, s1_inr_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  node_id_t         s1_dst_q, s1_dst_d;
  logic             out_valid_q, out_valid_d;
  rank_t            out_rank_q, out_rank_d;
  node_id_t         out_dst_q, out_dst_d;
  logic [15:0]      dropped_q, dropped_d;

  logic     edge_ready;
  logic     accept;
  logic     edge_in_range;
  rank_t    rank_sel;
  inv_deg_t inv_sel;
  rank_t    contrib;

  assign edge_ready    = (state_q == SCATTER);
  assign accept        = bus.edge_valid & edge_ready;
  assign edge_in_range = (bus.edge_src < node_id_t'(NODES_IN_GRAPH)) &&
                         (bus.edge_dst < node_id_t'(NODES_IN_GRAPH));

  // Out-of-range entries never index the tables, so non-power-of-two graphs stay in bounds.
  assign rank_sel = s1_inr_q ? pagerank_in[s1_idx_q]    : '0;
  assign inv_sel  = s1_inr_q ? inv_out_degree[s1_idx_q] : '0;

  pagerank_fixmul u_fixmul (
    .rank    (rank_sel),
    .inv_deg (inv_sel),
    .contrib (contrib)
  );

  always_comb begin
    state_d     = state_q;
    s1_valid_d  = 1'b0;
    s1_inr_d    = s1_inr_q;
    s1_idx_d    = s1_idx_q;
    s1_dst_d    = s1_dst_q;
    out_valid_d = s1_valid_q & s1_inr_q;
    out_rank_d  = out_rank_q;
    out_dst_d   = out_dst_q;
    dropped_d   = dropped_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_inr_d   = edge_in_range;
      s1_idx_d   = bus.edge_src[IDX_W-1:0];
      s1_dst_d   = bus.edge_dst;
      if (!edge_in_range && (dropped_q != 16'hFFFF)) begin
        dropped_d = dropped_q + 16'd1;
      end
    end

    if (out_valid_d) begin
      out_rank_d = contrib;
      out_dst_d  = s1_dst_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SCATTER;
          dropped_d = '0;
        end
      end
      SCATTER: begin
        if (accept && bus.edge_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Stage 1 empty now means stage 2 is presenting its final result this cycle.
        if (!s1_valid_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      s1_valid_q  <= 1'b0;
      s1_inr_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_dst_q    <= '0;
      out_valid_q <= 1'b0;
      out_rank_q  <= '0;
      out_dst_q   <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_inr_q    <= s1_inr_d;
      s1_idx_q    <= s1_idx_d;
      s1_dst_q    <= s1_dst_d;
      out_valid_q <= out_valid_d;
      out_rank_q  <= out_rank_d;
      out_dst_q   <= out_dst_d;
      dropped_q   <= dropped_d;
    end
  end

  assign bus.edge_ready             = edge_ready;
  assign bus.page_rank_scatter      = out_rank_q;
  assign bus.dest_id                = out_dst_q;
  assign bus.pagerank_ready         = out_valid_q;
  assign scatter_operation_complete = (state_q == DONE);
  assign dropped_edges              = dropped_q;
endmodule

// File: doc/pagerank_scatter.md
# pagerank_scatter

Scatter stage of the PageRank engine. Streams the edge list, and for every edge (src → dst) emits the contribution `rank[src] × inv_out_degree[src]` tagged with `dst`. It drives the gather stage's `page_rank_scatter` / `dest_id` / `pagerank_ready` inputs. It raises `scatter_operation_complete` once the last contribution of a pass has been emitted.

## Interface
- `NODES_IN_GRAPH`, 32, number of nodes; valid ids are 0..NODES_IN_GRAPH-1.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a scatter pass; honoured only in IDLE or DONE.
- `pagerank_in`  in  64 × [NODES_IN_GRAPH]  current ranks, unsigned Q32.32; held stable for the whole pass.
- `inv_out_degree`  in  33 × [NODES_IN_GRAPH]  1/out-degree, unsigned Q1.32 (0x1_00000000 = 1.0); held stable for the whole pass.
- `edge_valid`  in  1  edge on `edge_src`/`edge_dst` is valid.
- `edge_src`  in  32  source node id.
- `edge_dst`  in  32  destination node id.
- `edge_last`  in  1  final edge of the pass.
- `edge_ready`  out  1  edge accepted when `edge_valid & edge_ready`.
- `page_rank_scatter`  out  64  contribution, Q32.32.
- `dest_id`  out  32  destination of the contribution.
- `pagerank_ready`  out  1  one-cycle qualifier for `page_rank_scatter`/`dest_id`.
- `scatter_operation_complete`  out  1  level; high in DONE.
- `dropped_edges`  out  16  out-of-range edges this pass; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, SCATTER, DRAIN, DONE.
  - IDLE → SCATTER on `start`.
  - SCATTER → DRAIN on an accepted edge with `edge_last=1`.
  - DRAIN → DONE when both pipeline stages are empty.
  - DONE → SCATTER on `start`.
- `start` in SCATTER or DRAIN is ignored.
- `edge_ready` = 1 only in SCATTER. There is no output backpressure; the gather stage always accepts.
- Stage 1 registers the accepted edge: `src`, `dst`, and a range flag.
- Stage 2 forms a 97-bit product `pagerank_in[src] × inv_out_degree[src]`. The result is product bits [95:32]. It is registered to the outputs with `pagerank_ready=1`.
- Out-of-range edge (`src` or `dst` ≥ NODES_IN_GRAPH):
  - It propagates as a bubble; `pagerank_ready` stays 0 for it.
  - `dropped_edges` increments, saturating.
  - An out-of-range edge carrying `edge_last` still ends the pass.
- `inv_out_degree` = 0 yields a 0 contribution, which is still emitted.
- `page_rank_scatter`/`dest_id` hold their last value while `pagerank_ready`=0.
- On DONE → SCATTER, `dropped_edges` clears to 0 and `scatter_operation_complete` clears.
- Reset (any time, including mid-pass):
  - FSM to IDLE and pipeline flushed.
  - All outputs 0: `edge_ready`, `page_rank_scatter`, `dest_id`, `pagerank_ready`, `scatter_operation_complete`, `dropped_edges`.

## Timing
- An edge handshake in cycle c gives `pagerank_ready`=1 in cycle c+2. Fixed latency is 2.
- Throughput is one edge per cycle. Back-to-back accepted edges give consecutive `pagerank_ready` cycles in acceptance order.
- A last edge accepted in cycle c gives `scatter_operation_complete`=1 from cycle c+3. This is one cycle after the final `pagerank_ready`.
- `start` sampled high in IDLE/DONE in cycle s gives `edge_ready`=1 in cycle s+1. `scatter_operation_complete` falls in cycle s+1.
- `edge_last` with `edge_valid`=0 has no effect.

## Configuration
- Macro: `PAGERANK_SCATTER_SATURATE_EN`.
- Defined: if product bit 96 is set, `page_rank_scatter` = 0xFFFF_FFFF_FFFF_FFFF.
- Undefined: bit 96 is discarded; the result is plain truncation to bits [95:32].

## Structure
- Package `pagerank_pkg` holds:
  - `rank_t` (logic [63:0])
  - `node_id_t` (logic [31:0])
  - `inv_deg_t` (logic [32:0])
  - `FRAC_BITS` = 32
  - the scatter state enum `scatter_state_e`
- One sub-module, `pagerank_fixmul`: combinational 64×33 multiply, Q32.32 renormalisation and optional saturation. It is instantiated in stage 2.

## Test plan
- Single edge:
  - Stimulus: rank[0]=0x1_00000000, inv[0]=0x0_80000000, edge 0→3 with last, accepted in cycle c.
  - Required: cycle c+2 `pagerank_ready`=1, `dest_id`=3, `page_rank_scatter`=0x0_80000000. Cycle c+3 `scatter_operation_complete`=1.
- Burst:
  - Stimulus: 4 continuous edges 1→0, 2→0, 1→5, 2→7, with rank[1]=0x2_00000000, rank[2]=0x1_00000000, inv=1.0.
  - Required: 4 consecutive ready cycles with dst 0, 0, 5, 7 and values 0x2_00000000, 0x1_00000000, 0x2_00000000, 0x1_00000000.
- Range:
  - Stimulus: with NODES_IN_GRAPH=32, edge 0→32 with last.
  - Required: no `pagerank_ready`, `dropped_edges`=1, complete asserts normally.
- Overflow:
  - Stimulus: rank=0xFFFF_FFFF_FFFF_FFFF, inv=0x1_FFFF_FFFF.
  - Required: with the macro defined, output is 0xFFFF_FFFF_FFFF_FFFF. Without it, output is product[95:32].
- Reset:
  - Stimulus: `reset_n` low after 2 of 5 edges.
  - Required: all outputs 0 and FSM in IDLE. A fresh `start` then runs a full pass correctly.
- Control:
  - Stimulus: `start` pulsed mid-SCATTER, then `start` in DONE.
  - Required: the first is ignored. The second clears complete and `dropped_edges` next cycle, and `edge_ready`=1.
